// File: rtl/conv_pkg.sv
// Shared geometry, counter widths and FSM state type for the 3x3 window controller.
package conv_pkg;
  localparam int IMG_W    = 28;
  localparam int IMG_H    = 28;
  localparam int K        = 3;
  localparam int DW       = 16;
  localparam int LB_DEPTH = IMG_W - K;
  localparam int COL_W    = $clog2(IMG_W);
  localparam int ROW_W    = $clog2(IMG_H);
  localparam int WIN_CNT  = (IMG_W - K + 1) * (IMG_H - K + 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;
endpackage

// File: rtl/conv_pos_counter.sv
// Raster row/col position of the next pixel to be accepted; wraps back to 0,0
// after the last pixel so a new image always starts from the origin.
module conv_pos_counter
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  assign last = (row == ROW_MAX) && (col == COL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/conv_window_ctrl.sv
// 3x3 convolution line-buffer sequencer: pixel handshake, position tracking and
// window-valid flagging. Optional CONV_WIN_STALL_CNT_EN adds a stall_cnt output.
module conv_window_ctrl
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic             win_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             busy,
  output logic             done
`ifdef CONV_WIN_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);
  localparam logic [ROW_W-1:0] ROW_MIN = ROW_W'(K - 1);
  localparam logic [COL_W-1:0] COL_MIN = COL_W'(K - 1);

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             last;
  logic             hold;
  logic             in_win;
  logic             accept_start;

  // A window the MAC has not taken yet freezes the whole datapath.
  assign hold         = win_valid & ~out_ready;
  assign in_ready     = (state == STREAM) & ~hold;
  assign shift_en     = in_valid & in_ready;
  assign in_win       = (row >= ROW_MIN) && (col >= COL_MIN);
  assign accept_start = (state == IDLE) & start;

  conv_pos_counter u_pos (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept_start),
    .en   (shift_en),
    .row  (row),
    .col  (col),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= STREAM;
            busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (shift_en && last) state <= FLUSH;
        end
        FLUSH: begin
          if (!win_valid || out_ready) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase

      if (shift_en && in_win) begin
        win_valid <= 1'b1;
        win_row   <= row;
        win_col   <= col;
      end else if (out_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

`ifdef CONV_WIN_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE) begin
      if (start) stall_cnt <= '0;
    end else if (hold && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule
